// File: rtl/csi2_stat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csi2_stat_pkg
// Purpose  : Shared types and constants for the CSI-2 statistics monitor.
//            Holds the frame-tracking FSM encoding, the default widths and
//            the all-ones seed used for the min_* statistics.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package csi2_stat_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } stat_state_e;

  localparam int DEF_CNT_WIDTH  = 32;
  localparam int DEF_ERR_CH     = 3;
  localparam int DEF_FPS_WINDOW = 74250000;
  localparam int DEF_FPS_WIDTH  = 8;

  // All-ones seed for min_* statistics; users slice the low CNT_WIDTH bits,
  // so counter widths above MIN_INIT_W are not supported.
  localparam int                    MIN_INIT_W = 64;
  localparam logic [MIN_INIT_W-1:0] MIN_INIT   = '1;

endpackage
`default_nettype wire

// File: rtl/csi2_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : csi2_sat_cnt
// Purpose  : Saturating up-counter. Holds at all-ones instead of wrapping.
// Ports    : clk_i  - clock
//            srst_i - synchronous active-high reset
//            clr_i  - synchronous clear, wins over inc_i
//            inc_i  - increment request
//            cnt_o  - current count
//            sat_o  - increment requested while already at all-ones
// Revision : 1.0 - initial release
// ============================================================================
module csi2_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             w_at_max;

  assign w_at_max = &cnt_q;
  // Flags the lost event even when clr_i lands on the same cycle, so a
  // window-terminal increment at full scale is still reported.
  assign sat_o    = inc_i & w_at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !w_at_max) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csi2_stat_mon.sv
`default_nettype none
// ============================================================================
// Module   : csi2_stat_mon
// Purpose  : Snoops an AXI4-Stream video bus and receiver error strobes and
//            accumulates line/frame geometry, error counts, a frame counter
//            and a frames-per-window meter. All counters saturate and raise
//            a sticky overflow flag.
// Ports    : clk_i, srst_i          - pixel clock, sync active-high reset
//            clear_stat_i           - one-cycle pulse, clears statistics
//            video_t*_i             - snooped stream handshake/markers
//            err_i[ERR_CH]          - error strobes, one event per cycle
//            err_cnt_o              - packed per-channel error counts
//            max/min_px_per_ln_o    - line length extremes (beats)
//            max/min_ln_per_frame_o - frame height extremes (lines)
//            frame_cnt_o            - completed frames
//            fps_o                  - SOF count of the last full window
//            stat_valid_o           - at least one frame completed
//            overflow_o             - sticky saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module csi2_stat_mon
  import csi2_stat_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int ERR_CH     = DEF_ERR_CH,
  parameter int FPS_WINDOW = DEF_FPS_WINDOW,
  parameter int FPS_WIDTH  = DEF_FPS_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic                        clear_stat_i,
  input  logic                        video_tvalid_i,
  input  logic                        video_tready_i,
  input  logic                        video_tlast_i,
  input  logic                        video_tuser_i,
  input  logic [ERR_CH-1:0]           err_i,
  output logic [ERR_CH*CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0]        max_px_per_ln_o,
  output logic [CNT_WIDTH-1:0]        min_px_per_ln_o,
  output logic [CNT_WIDTH-1:0]        max_ln_per_frame_o,
  output logic [CNT_WIDTH-1:0]        min_ln_per_frame_o,
  output logic [CNT_WIDTH-1:0]        frame_cnt_o,
  output logic [FPS_WIDTH-1:0]        fps_o,
  output logic                        stat_valid_o,
  output logic                        overflow_o
);

  localparam int                   WIN_W      = $clog2(FPS_WINDOW);
  localparam logic [WIN_W-1:0]     c_WIN_LAST = WIN_W'(FPS_WINDOW - 1);
  localparam logic [CNT_WIDTH-1:0] c_MIN_INIT = MIN_INIT[CNT_WIDTH-1:0];

  stat_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] px_cnt_q, px_cnt_d, ln_cnt_q, ln_cnt_d;
  logic [CNT_WIDTH-1:0] max_px_q, max_px_d, min_px_q, min_px_d;
  logic [CNT_WIDTH-1:0] max_ln_q, max_ln_d, min_ln_q, min_ln_d;
  logic                 stat_valid_q, stat_valid_d, overflow_q, overflow_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [FPS_WIDTH-1:0] fps_q, fps_d;

  logic                 w_beat, w_sof, w_win_last;
  logic                 w_px_at_max, w_ln_at_max;
  logic [CNT_WIDTH-1:0] w_px_plus1, w_ln_plus1, w_line_len;
  logic                 w_line_done, w_frame_done, w_ovf_evt;
  logic [FPS_WIDTH-1:0] w_sof_cnt, w_sof_total;
  logic                 w_sof_sat, w_frame_sat;
  logic [ERR_CH-1:0]    w_err_inc, w_err_sat;

  // Everything presented in the clear cycle is dropped, SOF beats included.
  assign w_beat     = video_tvalid_i & video_tready_i & ~clear_stat_i;
  assign w_sof      = w_beat & video_tuser_i;
  assign w_win_last = (win_cnt_q == c_WIN_LAST);
  assign w_err_inc  = err_i & {ERR_CH{~clear_stat_i}};

  assign w_px_at_max = &px_cnt_q;
  assign w_ln_at_max = &ln_cnt_q;
  assign w_px_plus1  = w_px_at_max ? px_cnt_q : px_cnt_q + CNT_WIDTH'(1);
  assign w_ln_plus1  = w_ln_at_max ? ln_cnt_q : ln_cnt_q + CNT_WIDTH'(1);

  for (genvar k = 0; k < ERR_CH; k++) begin : g_err
    csi2_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
      .clk_i  (clk_i),
      .srst_i (srst_i),
      .clr_i  (clear_stat_i),
      .inc_i  (w_err_inc[k]),
      .cnt_o  (err_cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
      .sat_o  (w_err_sat[k])
    );
  end

  csi2_sat_cnt #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clr_i  (clear_stat_i),
    .inc_i  (w_frame_done),
    .cnt_o  (frame_cnt_o),
    .sat_o  (w_frame_sat)
  );

  // SOF counter restarts at each window end; clear_stat_i does not touch it.
  csi2_sat_cnt #(.WIDTH(FPS_WIDTH)) u_sof_cnt (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .clr_i  (w_win_last),
    .inc_i  (w_sof),
    .cnt_o  (w_sof_cnt),
    .sat_o  (w_sof_sat)
  );

  // Window result includes an SOF landing on the terminal cycle itself.
  assign w_sof_total = (w_sof && !(&w_sof_cnt)) ? w_sof_cnt + FPS_WIDTH'(1) : w_sof_cnt;

  always_comb begin
    win_cnt_d = w_win_last ? '0 : win_cnt_q + WIN_W'(1);
    fps_d     = w_win_last ? w_sof_total : fps_q;
  end

  always_comb begin
    state_d      = state_q;
    px_cnt_d     = px_cnt_q;
    ln_cnt_d     = ln_cnt_q;
    max_px_d     = max_px_q;
    min_px_d     = min_px_q;
    max_ln_d     = max_ln_q;
    min_ln_d     = min_ln_q;
    stat_valid_d = stat_valid_q;
    w_line_done  = 1'b0;
    w_line_len   = '0;
    w_frame_done = 1'b0;
    w_ovf_evt    = 1'b0;

    if (state_q == IN_FRAME && w_beat) begin
      if (video_tuser_i) begin
        // SOF closes the running frame; an unterminated last line is lost.
        w_frame_done = 1'b1;
        stat_valid_d = 1'b1;
        if (ln_cnt_q != '0) begin
          if (ln_cnt_q > max_ln_q) max_ln_d = ln_cnt_q;
          if (ln_cnt_q < min_ln_q) min_ln_d = ln_cnt_q;
        end
      end else if (video_tlast_i) begin
        w_line_done = 1'b1;
        w_line_len  = w_px_plus1;
        px_cnt_d    = '0;
        ln_cnt_d    = w_ln_plus1;
        w_ovf_evt   = w_px_at_max | w_ln_at_max;
      end else begin
        px_cnt_d  = w_px_plus1;
        w_ovf_evt = w_px_at_max;
      end
    end

    // Frame (re)start, common to both states.
    if (w_sof) begin
      state_d = IN_FRAME;
      if (video_tlast_i) begin
        w_line_done = 1'b1;
        w_line_len  = CNT_WIDTH'(1);
        px_cnt_d    = '0;
        ln_cnt_d    = CNT_WIDTH'(1);
      end else begin
        px_cnt_d = CNT_WIDTH'(1);
        ln_cnt_d = '0;
      end
    end

    if (w_line_done) begin
      if (w_line_len > max_px_q) max_px_d = w_line_len;
      if (w_line_len < min_px_q) min_px_d = w_line_len;
    end

    overflow_d = overflow_q | w_ovf_evt | w_frame_sat | w_sof_sat | (|w_err_sat);

    if (clear_stat_i) begin
      state_d      = WAIT_SOF;
      px_cnt_d     = '0;
      ln_cnt_d     = '0;
      max_px_d     = '0;
      min_px_d     = c_MIN_INIT;
      max_ln_d     = '0;
      min_ln_d     = c_MIN_INIT;
      stat_valid_d = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= WAIT_SOF;
      px_cnt_q     <= '0;
      ln_cnt_q     <= '0;
      max_px_q     <= '0;
      min_px_q     <= c_MIN_INIT;
      max_ln_q     <= '0;
      min_ln_q     <= c_MIN_INIT;
      stat_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      win_cnt_q    <= '0;
      fps_q        <= '0;
    end else begin
      state_q      <= state_d;
      px_cnt_q     <= px_cnt_d;
      ln_cnt_q     <= ln_cnt_d;
      max_px_q     <= max_px_d;
      min_px_q     <= min_px_d;
      max_ln_q     <= max_ln_d;
      min_ln_q     <= min_ln_d;
      stat_valid_q <= stat_valid_d;
      overflow_q   <= overflow_d;
      win_cnt_q    <= win_cnt_d;
      fps_q        <= fps_d;
    end
  end

  assign max_px_per_ln_o    = max_px_q;
  assign min_px_per_ln_o    = min_px_q;
  assign max_ln_per_frame_o = max_ln_q;
  assign min_ln_per_frame_o = min_ln_q;
  assign fps_o              = fps_q;
  assign stat_valid_o       = stat_valid_q;
  assign overflow_o         = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2_stat_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi2_stat_mon
// Purpose  : Self-checking bench for csi2_stat_mon. Stimulus pushes the
//            hand-computed expected output snapshot into a queue; a monitor
//            pops and compares against the DUT on the falling edge.
//            A second instance with 4-bit counters exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi2_stat_mon;

  localparam int CW  = 32;
  localparam int EC  = 3;
  localparam int WIN = 1000;
  localparam int FW  = 8;
  localparam int SCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, clear, tvalid, tready, tlast, tuser;
  logic [EC-1:0] err;
  logic [EC*CW-1:0] err_cnt;
  logic [CW-1:0] max_px, min_px, max_ln, min_ln, frame_cnt;
  logic [FW-1:0] fps;
  logic stat_valid, ovf;

  logic clear_s;
  logic [EC-1:0] err_s;
  logic [EC*SCW-1:0] s_err_cnt;
  logic [SCW-1:0] s_max_px, s_min_px, s_max_ln, s_min_ln, s_frame_cnt;
  logic [FW-1:0] s_fps;
  logic s_stat_valid, s_ovf;

  csi2_stat_mon #(.CNT_WIDTH(CW), .ERR_CH(EC), .FPS_WINDOW(WIN), .FPS_WIDTH(FW)) dut (
    .clk_i(clk), .srst_i(srst), .clear_stat_i(clear),
    .video_tvalid_i(tvalid), .video_tready_i(tready),
    .video_tlast_i(tlast), .video_tuser_i(tuser), .err_i(err),
    .err_cnt_o(err_cnt), .max_px_per_ln_o(max_px), .min_px_per_ln_o(min_px),
    .max_ln_per_frame_o(max_ln), .min_ln_per_frame_o(min_ln),
    .frame_cnt_o(frame_cnt), .fps_o(fps), .stat_valid_o(stat_valid),
    .overflow_o(ovf)
  );

  csi2_stat_mon #(.CNT_WIDTH(SCW), .ERR_CH(EC), .FPS_WINDOW(WIN), .FPS_WIDTH(FW)) dut_s (
    .clk_i(clk), .srst_i(srst), .clear_stat_i(clear_s),
    .video_tvalid_i(1'b0), .video_tready_i(1'b0),
    .video_tlast_i(1'b0), .video_tuser_i(1'b0), .err_i(err_s),
    .err_cnt_o(s_err_cnt), .max_px_per_ln_o(s_max_px), .min_px_per_ln_o(s_min_px),
    .max_ln_per_frame_o(s_max_ln), .min_ln_per_frame_o(s_min_ln),
    .frame_cnt_o(s_frame_cnt), .fps_o(s_fps), .stat_valid_o(s_stat_valid),
    .overflow_o(s_ovf)
  );

  // Field indices of an expected snapshot.
  localparam int NF = 13;
  localparam int F_ERR0 = 0, F_ERR1 = 1, F_ERR2 = 2, F_MAXPX = 3, F_MINPX = 4;
  localparam int F_MAXLN = 5, F_MINLN = 6, F_FRAME = 7, F_FPS = 8, F_SV = 9;
  localparam int F_OVF = 10, F_SERR0 = 11, F_SOVF = 12;
  string fname [NF] = '{"err0", "err1", "err2", "max_px", "min_px", "max_ln",
                        "min_ln", "frame_cnt", "fps", "stat_valid", "overflow",
                        "s_err0", "s_overflow"};

  typedef struct {
    string               tag;
    logic [NF-1:0][31:0] v;
    logic [NF-1:0]       care;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;

  // Window position reference: counts edges since reset was last sampled.
  always @(posedge clk) begin
    if (srst) edges <= 0;
    else      edges <= edges + 1;
  end

  exp_t                mon_e;
  logic [NF-1:0][31:0] mon_a;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a[F_ERR0]  = err_cnt[0*CW +: CW];
      mon_a[F_ERR1]  = err_cnt[1*CW +: CW];
      mon_a[F_ERR2]  = err_cnt[2*CW +: CW];
      mon_a[F_MAXPX] = max_px;
      mon_a[F_MINPX] = min_px;
      mon_a[F_MAXLN] = max_ln;
      mon_a[F_MINLN] = min_ln;
      mon_a[F_FRAME] = frame_cnt;
      mon_a[F_FPS]   = {24'd0, fps};
      mon_a[F_SV]    = {31'd0, stat_valid};
      mon_a[F_OVF]   = {31'd0, ovf};
      mon_a[F_SERR0] = {28'd0, s_err_cnt[SCW-1:0]};
      mon_a[F_SOVF]  = {31'd0, s_ovf};
      for (int i = 0; i < NF; i++) begin
        if (mon_e.care[i]) begin
          n_tests++;
          if (mon_a[i] !== mon_e.v[i]) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d (0x%0h), expected %0d (0x%0h)",
                     mon_e.tag, fname[i], mon_a[i], mon_a[i], mon_e.v[i], mon_e.v[i]);
          end
        end
      end
    end
  end

  // Reset-state snapshot, fps not checked.
  function automatic exp_t mk(input string tag);
    exp_t e;
    e.tag  = tag;
    e.v    = '0;
    e.care = '1;
    e.care[F_FPS]  = 1'b0;
    e.v[F_MINPX]   = 32'hFFFF_FFFF;
    e.v[F_MINLN]   = 32'hFFFF_FFFF;
    return e;
  endfunction

  // fps-only snapshot.
  function automatic exp_t mkf(input string tag, input int f);
    exp_t e;
    e = mk(tag);
    e.care         = '0;
    e.care[F_FPS]  = 1'b1;
    e.v[F_FPS]     = 32'(f);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stats(input string tag, input int mxp, input int mnp,
                            input int mxl, input int mnl, input int frames);
    exp_t e;
    e = mk(tag);
    e.v[F_MAXPX] = 32'(mxp);
    e.v[F_MINPX] = 32'(mnp);
    e.v[F_MAXLN] = 32'(mxl);
    e.v[F_MINLN] = 32'(mnl);
    e.v[F_FRAME] = 32'(frames);
    e.v[F_SV]    = 32'd1;
    q.push_back(e);
  endtask

  // One beat; with rnd set, tready is randomly withheld (bounded).
  task automatic send_beat(input logic u, input logic l, input bit rnd);
    int tries;
    tries  = 0;
    tvalid = 1'b1;
    tuser  = u;
    tlast  = l;
    forever begin
      tready = (rnd && tries < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      tries++;
      step();
      if (tready) break;
    end
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_line(input int n, input bit sof, input bit rnd);
    for (int i = 0; i < n; i++) send_beat(sof && i == 0, i == n - 1, rnd);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic to_terminal();
    while (edges % WIN != WIN - 1) step();
  endtask

  initial begin
    exp_t e;
    srst = 1'b1; clear = 1'b0; clear_s = 1'b0;
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tuser = 1'b0;
    err = '0; err_s = '0;
    repeat (3) step();
    srst = 1'b0;
    e = mk("reset");
    e.care[F_FPS] = 1'b1;
    q.push_back(e);

    // Three 4x10 frames with random backpressure; frame 3 still open.
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 4; l++) send_line(10, l == 0, 1'b1);
    push_stats("3frames", 10, 10, 4, 4, 2);
    pulse_clear();
    q.push_back(mk("clear1"));

    // Mid-frame start: lines before the first SOF are not measured.
    send_line(3, 1'b0, 1'b1);
    send_line(3, 1'b0, 1'b1);
    q.push_back(mk("no_sof"));
    send_line(7, 1'b1, 1'b1);
    for (int l = 0; l < 4; l++) send_line(7, 1'b0, 1'b1);
    send_beat(1'b1, 1'b0, 1'b1);
    push_stats("midframe", 7, 7, 5, 5, 1);
    pulse_clear();
    q.push_back(mk("clear2"));

    // Mixed line lengths, then a zero-height frame and an SOF+EOL beat.
    send_line(8, 1'b1, 1'b1);
    send_line(12, 1'b0, 1'b1);
    send_line(5, 1'b0, 1'b1);
    send_beat(1'b1, 1'b0, 1'b1);
    push_stats("mixed", 12, 5, 3, 3, 1);
    send_beat(1'b1, 1'b1, 1'b1);
    send_beat(1'b1, 1'b0, 1'b1);
    push_stats("zero_ht", 12, 1, 3, 1, 3);
    pulse_clear();

    // Error counters and clear priority.
    err = 3'b101;
    repeat (20) step();
    e = mk("err20");
    e.v[F_ERR0] = 32'd20;
    e.v[F_ERR2] = 32'd20;
    q.push_back(e);
    pulse_clear();
    err = 3'b010;
    q.push_back(mk("err_clr"));
    repeat (4) step();
    err = 3'b000;
    e = mk("err4");
    e.v[F_ERR1] = 32'd4;
    q.push_back(e);
    pulse_clear();

    // 4-bit counter saturation on the second instance.
    err_s = 3'b001;
    repeat (20) step();
    err_s = 3'b000;
    e = mk("sat");
    e.v[F_SERR0] = 32'd15;
    e.v[F_SOVF]  = 32'd1;
    q.push_back(e);
    repeat (5) step();
    e.tag = "sat_hold";
    q.push_back(e);
    clear_s = 1'b1;
    step();
    clear_s = 1'b0;
    q.push_back(mk("sat_clr"));

    // FPS meter: get a fully quiet window first.
    to_terminal(); step();
    to_terminal(); step();
    q.push_back(mkf("fps_quiet", 0));
    for (int i = 0; i < 6; i++) begin
      send_beat(1'b1, 1'b0, 1'b0);
      step();
    end
    to_terminal();
    q.push_back(mkf("fps_pre", 0));
    send_beat(1'b1, 1'b0, 1'b0);
    q.push_back(mkf("fps7", 7));
    while (edges % WIN != WIN / 2) step();
    pulse_clear();
    e = mk("clr_fps");
    e.care[F_FPS] = 1'b1;
    e.v[F_FPS]    = 32'd7;
    q.push_back(e);
    to_terminal();
    q.push_back(mkf("fps_hold", 7));
    step();
    q.push_back(mkf("fps0", 0));
    for (int i = 0; i < 3; i++) begin
      send_beat(1'b1, 1'b0, 1'b0);
      step();
    end
    to_terminal(); step();
    q.push_back(mkf("fps3", 3));

    // Reset in the middle of a frame.
    send_beat(1'b1, 1'b0, 1'b0);
    send_beat(1'b0, 1'b1, 1'b0);
    send_beat(1'b0, 1'b0, 1'b0);
    err = 3'b111;
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    err  = 3'b000;
    e = mk("srst");
    e.care[F_FPS] = 1'b1;
    q.push_back(e);

    step();
    step();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d snapshots left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csi2_stat_mon.md
Name: csi2_stat_mon

Overview:
- Parametrised successor of the CSI-2 receiver statistics accumulator. Sits in the pixel-clock domain beside csi2_csr and snoops the AXI4-Stream video output and the receiver error strobes.
- Adds four things the previous block lacked: a configurable number of error channels, a configurable counter width, saturating counters with a sticky overflow flag, and a frame-rate meter.
- Frame and line statistics are gated by a start-of-frame synchroniser, so partial frames after reset or clear are never measured.

Parameters:
- CNT_WIDTH, 32, width of every counter and statistic output.
- ERR_CH, 3, number of independent error event inputs.
- FPS_WINDOW, 74250000, measurement window in clk_i cycles (1 s at 74.25 MHz); must be at least 2.
- FPS_WIDTH, 8, width of the frames-per-window result.

Ports:
- clk_i  in  1  pixel clock; single clock domain.
- srst_i  in  1  reset, synchronous, active-high.
- clear_stat_i  in  1  single-cycle pulse; clears all statistics.
- video_tvalid_i  in  1  snooped stream valid.
- video_tready_i  in  1  snooped stream ready.
- video_tlast_i  in  1  end of line.
- video_tuser_i  in  1  start of frame (first pixel).
- err_i  in  ERR_CH  error strobes; one event per high cycle per bit.
- err_cnt_o  out  ERR_CH x CNT_WIDTH  per-channel error counts.
- max_px_per_ln_o / min_px_per_ln_o  out  CNT_WIDTH  line length extremes, in beats.
- max_ln_per_frame_o / min_ln_per_frame_o  out  CNT_WIDTH  frame height extremes, in lines.
- frame_cnt_o  out  CNT_WIDTH  completed frames.
- fps_o  out  FPS_WIDTH  start-of-frame count in the last full window.
- stat_valid_o  out  1  at least one complete frame measured.
- overflow_o  out  1  sticky; any counter or statistic saturated.

Behaviour:
- Beat = video_tvalid_i & video_tready_i. Only beats are counted; tvalid without tready is ignored.
- Reset values:
  - min_* outputs: all-ones.
  - All other outputs: 0.
  - FSM state: WAIT_SOF.
- All outputs are registered. A statistic updates on the clk_i edge after the beat that completes it (1-cycle latency).
- FSM WAIT_SOF:
  - Ignores everything except a beat with tuser=1.
  - On that beat: go to IN_FRAME, px_cnt=1, ln_cnt=0.
  - If the same beat also has tlast=1: line length 1 is recorded, ln_cnt=1, px_cnt=0.
- FSM IN_FRAME:
  - Each beat increments px_cnt.
  - tlast beat: line length = px_cnt+1. Update max/min px. px_cnt<=0, ln_cnt<=ln_cnt+1.
  - tuser beat: closes the previous frame with height = ln_cnt. Update max/min ln, frame_cnt+1, stat_valid_o<=1. Then restart as in WAIT_SOF. A trailing line with no tlast is discarded.
  - Frames with ln_cnt=0 (SOF, no completed line, SOF again) are not recorded as height 0; frame_cnt still increments.
- Min/max comparisons are unsigned: min takes the new value if smaller, max takes it if larger.
- Saturation: every counter (px_cnt, ln_cnt, err_cnt_o[k], frame_cnt_o) holds at all-ones instead of wrapping and sets overflow_o. fps internal count saturates at 2^FPS_WIDTH-1, also setting overflow_o.
- Error counters increment independently and simultaneously. They are counted in both FSM states and are not gated by the stream.
- FPS meter:
  - win_cnt runs 0..FPS_WINDOW-1 continuously from reset and is not affected by clear_stat_i.
  - sof_cnt counts tuser beats in both FSM states.
  - In the terminal cycle: fps_o<=sof_cnt plus the SOF in that cycle, if any. sof_cnt<=0.
- clear_stat_i:
  - Next cycle: all outputs return to reset values except fps_o, which holds; FSM goes to WAIT_SOF.
  - Beats and err_i in the clear cycle are dropped, including a SOF beat.
  - Clear has priority over simultaneous events.
- srst_i mid-frame: everything returns to reset state, including win_cnt and fps_o. No partial statistics are retained.

Decomposition:
- Package csi2_stat_pkg:
  - FSM enum typedef (WAIT_SOF, IN_FRAME).
  - Default width constants.
  - MIN_INIT all-ones localparam helper.
- One sub-module, csi2_sat_cnt: parametrised width; inputs clr, inc; outputs cnt, sat. Instantiated for each err channel, frame_cnt and sof_cnt.
- Min/max and FSM logic stay inline.

Test Plan (CNT_WIDTH=32, ERR_CH=3, FPS_WINDOW=1000, FPS_WIDTH=8 unless stated):
- After reset, stream 3 frames of 4 lines x 10 beats, tready random 50% -> min/max_px=10, min/max_ln=4, frame_cnt_o=2, stat_valid_o=1 one cycle after the 3rd SOF beat.
- Start streaming mid-frame (2 lines, no tuser), then 1 SOF, 5 lines of 7, SOF -> no stats from the first 2 lines; px=7/7, ln=5/5, frame_cnt_o=1.
- Line lengths 8,12,5 within one frame, then SOF -> max_px=12, min_px=5, ln=3.
- err_i=3'b101 for 20 cycles, 3'b010 for 4 cycles, clear_stat_i coincident with the 21st cycle of 3'b101 -> counts 20,0,20 then 0,0,0 after clear, then 0,4,0; overflow_o=0.
- CNT_WIDTH=4: err_i[0] high 20 cycles -> err_cnt_o[0]=15, overflow_o=1 and stays 1 until clear.
- 7 SOF beats within one 1000-cycle window, one of them on the terminal cycle -> fps_o=7 at the boundary; next window with 0 SOF -> fps_o=0; clear_stat_i mid-window leaves fps_o unchanged.
